// File: rtl/uart_tx.sv
// UART serial transmitter: valid/ready byte intake, framed LSB-first serial output
// with optional parity and one or two stop bits. The line idles high.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic              PARITY_INV = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d is the line level of the state being entered, so tx stays registered
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ PARITY_INV;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter, the transmit-side counterpart of the receive path's start-bit edge detector and receiver. It accepts parallel bytes through a valid/ready handshake and serialises each byte as an asynchronous frame: start bit, LSB-first data, optional parity, then stop bit(s). It sits between the host-side TX interface and the `tx` pad, and keeps the line idle-high whenever no frame is in flight.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit period (100 MHz / 115200); legal values ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal values 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk` input 1: single clock; all logic is rising-edge.
- `arst_n` input 1: asynchronous, active-low reset.
- `tx_data` input DATA_BITS: byte to send; sampled only at the handshake.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: transmitter can accept a byte (high only in IDLE).
- `tx` output 1: serial line, registered, idle high.
- `tx_busy` output 1: a frame is in progress (equals the inverse of `tx_ready`).
- `tx_done` output 1: one-cycle pulse marking frame completion.

## Operation
- Handshake: a byte is accepted on the rising edge where `tx_valid && tx_ready`. `tx_data` is copied into a shift register and the FSM leaves IDLE. `tx_valid` during a frame is ignored, and `tx_data` is not re-sampled.
- FSM states and transitions:
  - IDLE → START on handshake.
  - START → DATA.
  - DATA → PARITY if `PARITY_EN`, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Each non-IDLE state holds for exactly `CLKS_PER_BIT` cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT). The counter clears on entry to each state and on each data-bit advance.
- DATA repeats `DATA_BITS` times. `tx` drives shift-register bit 0, and the register shifts right at each bit boundary, so data goes out LSB first.
- Parity bit: XOR of the latched data bits, inverted when `PARITY_ODD`=1. It is computed from the latched copy, not from live `tx_data`.
- STOP drives `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
- Line levels: `tx`=0 in START; `tx`=1 in IDLE and STOP.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, FSM in IDLE, counters and shift register zero.
- Reset mid-frame: outputs take their reset values immediately (asynchronous). The frame is abandoned, and no `tx_done` is produced for it.

## Timing
- Handshake at edge E: `tx` falls and `tx_ready` drops in the cycle after E (both registered). This is one cycle of latency.
- Frame length `F` = `CLKS_PER_BIT` × (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) cycles of non-idle state.
- `tx_ready` returns high F cycles after it dropped. `tx_done` is high in that same single cycle.
- Back-to-back: if `tx_valid` is held high, the next handshake happens in the first cycle `tx_ready` is high. The next start bit then begins one cycle later, so the inter-frame idle gap is exactly 1 cycle of `tx`=1 beyond the stop bit(s).
- Glitch-free line: `tx` changes only at bit boundaries and is never combinationally derived.

## Test plan
- Reset checks:
  - Assert `arst_n`=0 with no clock running → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - After release, `tx` stays 1 until a handshake.
- Single byte, defaults except `CLKS_PER_BIT`=4:
  - Send 0xA5.
  - `tx` shows 0, then bits 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total).
  - `tx_done` pulses once, 40 cycles after `tx_ready` drops.
- Parity (`PARITY_EN`=1, `CLKS_PER_BIT`=4):
  - Send 0x07 with even parity → parity bit 1.
  - Send 0x07 with `PARITY_ODD`=1 → parity bit 0.
  - Frame is 44 cycles.
- Back-to-back with `STOP_BITS`=2:
  - Hold `tx_valid`=1 with 0x55 then 0x0F.
  - Second start bit falls exactly 1 idle cycle after the 8-cycle stop period.
  - Both bytes decode correctly, with two `tx_done` pulses.
- Busy-time stimulus:
  - During a frame carrying 0x3C, toggle `tx_valid` and change `tx_data` to 0xFF.
  - Serial output still carries 0x3C, and no extra frame is sent.
- Reset mid-frame:
  - Assert `arst_n` during the DATA state of 0x00 → `tx` goes to 1 immediately, with no `tx_done`.
  - After release, a new byte 0x81 transmits correctly.
